// File: rtl/paddle_tracker_if.sv
// Bundles the coordinate input, enable and paddle outputs of paddle_tracker.
// Latency: none, wiring only.
// Backpressure: none; coord_V_ap_vld is a single-cycle qualifier with no ready.
interface paddle_tracker_if #(
  parameter int COORD_W = 10
);
  logic               enable;
  logic [COORD_W-1:0] coord_V;
  logic               coord_V_ap_vld;
  logic [COORD_W-1:0] paddle_top;
  logic               paddle_upd;
  logic               tracking;
  logic               lost;

  modport master (
    output enable, coord_V, coord_V_ap_vld,
    input  paddle_top, paddle_upd, tracking, lost
  );

  modport slave (
    input  enable, coord_V, coord_V_ap_vld,
    output paddle_top, paddle_upd, tracking, lost
  );
endinterface

// File: rtl/paddle_tracker.sv
// Turns per-frame target coordinates into a filtered, clamped paddle position.
// Latency: 3 cycles from accepted sample to paddle_upd; II=1, no backpressure.
// Optional build macro PADDLE_DEADBAND_EN suppresses updates within DEADBAND of filt.
module paddle_tracker #(
  parameter int COORD_W   = 10,
  parameter int Y_MAX     = 479,
  parameter int PADDLE_H  = 64,
  parameter int AVG_SHIFT = 2,
  parameter int MAX_STEP  = 16,
  parameter int TIMEOUT   = 10_000_000,
  parameter int DEADBAND  = 2
) (
  input logic             clk,
  input logic             RESET,
  paddle_tracker_if.slave bus
);
  // Two guard bits so med - filt and filt + step never overflow.
  localparam int DW    = COORD_W + 2;
  localparam int CNT_W = $clog2(TIMEOUT);

  localparam logic [COORD_W-1:0] TOP_RST   = COORD_W'((Y_MAX + 1 - PADDLE_H) / 2);
  localparam logic [COORD_W-1:0] FILT_RST  = COORD_W'((Y_MAX + 1) / 2);
  localparam logic [COORD_W-1:0] YMAX_C    = COORD_W'(Y_MAX);
  localparam logic [COORD_W-1:0] TOP_MAX_U = COORD_W'(Y_MAX + 1 - PADDLE_H);
  localparam logic signed [DW-1:0] TOP_MAX = DW'(Y_MAX + 1 - PADDLE_H);
  localparam logic signed [DW-1:0] HALF_H  = DW'(PADDLE_H / 2);
  localparam logic signed [DW-1:0] STEP_HI = DW'(MAX_STEP);
  localparam logic signed [DW-1:0] STEP_LO = DW'(-MAX_STEP);
  localparam logic signed [DW-1:0] DB_HI   = DW'(DEADBAND);
  localparam logic signed [DW-1:0] DB_LO   = DW'(-DEADBAND);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(TIMEOUT - 1);

`ifdef PADDLE_DEADBAND_EN
  localparam logic DB_EN = 1'b1;
`else
  localparam logic DB_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK, LOST} state_t;

  state_t             state, state_nxt;
  logic               acc, lost_set, lost_q;
  logic [CNT_W-1:0]   cnt;
  logic [COORD_W-1:0] h0, h1, h2, med_c, med, lo01, hi01, mid;
  logic               s1_vld, s1_byp, s2_vld, s2_byp;
  logic [COORD_W-1:0] filt, top_q, top_nxt;
  logic               upd_q, skip, near;
  logic signed [DW-1:0] d, sh, step, sum, top_s;

  // Range check: out-of-range coordinates are simply never accepted.
  assign acc = bus.coord_V_ap_vld & bus.enable & (bus.coord_V <= YMAX_C);

  // Next-state logic; a sample arriving while IDLE is treated as the acquiring one.
  always_comb begin
    state_nxt = state;
    lost_set  = 1'b0;
    if (!bus.enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = acc ? TRACK : ACQUIRE;
        ACQUIRE: if (acc) state_nxt = TRACK;
        TRACK:   if (!acc && cnt == CNT_LAST) begin
                   state_nxt = LOST;
                   lost_set  = 1'b1;
                 end
        LOST:    if (acc) state_nxt = TRACK;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  // Timeout counter: cleared by accepted samples, saturates at TIMEOUT-1.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET)                cnt <= '0;
    else if (acc)             cnt <= '0;
    else if (cnt != CNT_LAST) cnt <= cnt + CNT_W'(1);
  end

  // Single-cycle lost pulse on entry to LOST.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) lost_q <= 1'b0;
    else       lost_q <= lost_set;
  end

  // S1: history shift; after IDLE/ACQUIRE/LOST the history is re-primed with the sample.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      h0 <= '0; h1 <= '0; h2 <= '0;
      s1_vld <= 1'b0; s1_byp <= 1'b0;
    end else begin
      s1_vld <= acc;
      if (acc) begin
        s1_byp <= (state == IDLE) || (state == ACQUIRE);
        h0     <= bus.coord_V;
        if (state == TRACK) begin
          h1 <= h0;
          h2 <= h1;
        end else begin
          h1 <= bus.coord_V;
          h2 <= bus.coord_V;
        end
      end
    end
  end

  // Median of three: max(min(h0,h1), min(max(h0,h1), h2)).
  always_comb begin
    lo01  = (h0 < h1) ? h0 : h1;
    hi01  = (h0 < h1) ? h1 : h0;
    mid   = (hi01 < h2) ? hi01 : h2;
    med_c = (lo01 > mid) ? lo01 : mid;
  end

  // S2: register the median; dropping enable kills the sample in flight.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      med <= '0; s2_vld <= 1'b0; s2_byp <= 1'b0;
    end else begin
      med    <= med_c;
      s2_vld <= s1_vld & bus.enable;
      s2_byp <= s1_byp;
    end
  end

  // S3 math: rate-limited IIR step (acquire bypasses it), then playfield clamp.
  always_comb begin
    d    = $signed({2'b00, med}) - $signed({2'b00, filt});
    sh   = d >>> AVG_SHIFT;
    step = (sh > STEP_HI) ? STEP_HI : ((sh < STEP_LO) ? STEP_LO : sh);
    sum  = s2_byp ? $signed({2'b00, med}) : ($signed({2'b00, filt}) + step);
    top_s = sum - HALF_H;
    if (top_s < 0)            top_nxt = '0;
    else if (top_s > TOP_MAX) top_nxt = TOP_MAX_U;
    else                      top_nxt = top_s[COORD_W-1:0];
    near = (d < DB_HI) && (d > DB_LO);
    skip = DB_EN & ~s2_byp & near;
  end

  // S3: commit filt and paddle_top together with the update pulse.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      filt  <= FILT_RST;
      top_q <= TOP_RST;
      upd_q <= 1'b0;
    end else begin
      upd_q <= s2_vld & bus.enable & ~skip;
      if (s2_vld & bus.enable & ~skip) begin
        filt  <= sum[COORD_W-1:0];
        top_q <= top_nxt;
      end
    end
  end

  assign bus.paddle_top = top_q;
  assign bus.paddle_upd = upd_q;
  assign bus.tracking   = (state == TRACK);
  assign bus.lost       = lost_q;
endmodule

// File: tb/tb_paddle_tracker.sv
// Directed bench for paddle_tracker with a scoreboard queue and an output monitor.
// Built with TIMEOUT=100 so the loss-of-target paths are reachable quickly.
module tb_paddle_tracker;
  localparam int TOUT = 100;

  logic clk = 1'b0;
  logic RESET;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   lost_cnt = 0;
  int   lost_at = -1;
  int   last_drv = 0;

  typedef struct {
    int top;
    int trk;
    int cyc;
  } exp_t;
  exp_t q[$];

  paddle_tracker_if #(.COORD_W(10)) bus ();

  paddle_tracker #(.TIMEOUT(TOUT)) dut (
    .clk  (clk),
    .RESET(RESET),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Monitor: every paddle_upd must match the oldest expected update.
  always @(negedge clk) begin
    if (bus.paddle_upd) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_upd: got paddle_top=%0d, expected no update (cycle %0d)",
                 bus.paddle_top, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("upd_top", int'(bus.paddle_top), e.top);
        chk("upd_trk", int'(bus.tracking), e.trk);
        chk("upd_cycle", cyc, e.cyc);
      end
    end
    if (bus.lost) begin
      lost_cnt++;
      lost_at = cyc;
    end
  end

  // Drive one sample for one cycle; caller must be at a negedge.
  task automatic send(input int v, input bit expect_upd, input int etop);
    bus.coord_V        = 10'(v);
    bus.coord_V_ap_vld = 1'b1;
    last_drv           = cyc;
    if (expect_upd) q.push_back('{etop, 1, cyc + 3});
    @(negedge clk);
    bus.coord_V_ap_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    int c_a;
    RESET              = 1'b1;
    bus.enable         = 1'b0;
    bus.coord_V        = '0;
    bus.coord_V_ap_vld = 1'b0;
    idle(3);
    RESET = 1'b0;
    idle(1);
    chk("rst_top", int'(bus.paddle_top), 208);
    chk("rst_trk", int'(bus.tracking), 0);
    chk("rst_lost", int'(bus.lost), 0);
    chk("rst_upd", int'(bus.paddle_upd), 0);

    // Acquire at 300, then median/rate-limit with two back-to-back 400s.
    bus.enable = 1'b1;
    idle(2);
    send(300, 1, 268);
    send(400, 1, 268);
    send(400, 1, 284);
    c_a = last_drv;
    idle(10);
    // Out-of-range sample: dropped, timer keeps running.
    send(500, 0, 0);
    chk("trk_after_500", int'(bus.tracking), 1);

    // Timeout measured from the last accepted 400.
    wait_until(c_a + TOUT + 3);
    chk("lost_pulses", lost_cnt, 1);
    chk("lost_cycle", lost_at, c_a + TOUT + 1);
    chk("lost_trk", int'(bus.tracking), 0);
    chk("lost_hold_top", int'(bus.paddle_top), 284);

    // Recovery from LOST: filt 316, sample 100 -> step -16, filt 300.
    send(100, 1, 268);
    c_a = last_drv;
    chk("recover_trk", int'(bus.tracking), 1);

    // Sample lands exactly when the counter reaches TIMEOUT-1: no LOST.
    wait_until(c_a + TOUT);
    send(300, 1, 252);
    idle(5);
    chk("boundary_lost_pulses", lost_cnt, 1);
    chk("boundary_trk", int'(bus.tracking), 1);

    // Prime at 5 -> clamp low; prime at 470 -> clamp high.
    bus.enable = 1'b0;
    idle(2);
    bus.enable = 1'b1;
    idle(2);
    send(5, 1, 0);
    idle(3);
    bus.enable = 1'b0;
    idle(2);
    bus.enable = 1'b1;
    idle(2);
    send(470, 1, 416);
    idle(4);

    // Drop enable one cycle after acceptance: result discarded.
    send(300, 0, 0);
    bus.enable = 1'b0;
    idle(1);
    chk("endrop_trk", int'(bus.tracking), 0);
    idle(5);
    chk("endrop_top_hold", int'(bus.paddle_top), 416);

    // RESET mid-pipeline.
    bus.enable = 1'b1;
    idle(2);
    send(200, 0, 0);
    chk("pre_reset_trk", int'(bus.tracking), 1);
    RESET = 1'b1;
    #1;
    chk("midrst_top", int'(bus.paddle_top), 208);
    chk("midrst_trk", int'(bus.tracking), 0);
    chk("midrst_upd", int'(bus.paddle_upd), 0);
    chk("midrst_lost", int'(bus.lost), 0);
    idle(2);
    RESET = 1'b0;
    idle(6);
    chk("postrst_top", int'(bus.paddle_top), 208);

`ifdef PADDLE_DEADBAND_EN
    // Median within DEADBAND of filt: no update.
    send(300, 1, 268);
    send(301, 0, 0);
    send(301, 0, 0);
    idle(5);
    chk("deadband_top", int'(bus.paddle_top), 268);
`endif

    idle(4);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
